pipe_regfile_fwd: RTL and testbench
===================================

Name: pipe_regfile_fwd

Overview:
Parametrised general-purpose register file for the pipelined 16-bit CPU, with NRD registered read ports and one write port. It forwards from the execute and writeback stages, and keeps a load-pending scoreboard that raises a stall on load-use hazards. It sits between the RF-read stage and the writeback stage. It replaces hand-coded per-register muxing, and adds a link-register port for call/callr.

Parameters:
DATA_W, 16, register width in bits
NREGS, 8, number of registers; power of two, >=2; ADDR_W = $clog2(NREGS) derived internally
NRD, 2, number of read ports, 1..4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_rd_en  in  1  read request for all ports this cycle
i_rd_addr  in  NRD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W]
o_rd_data  out  NRD*DATA_W  registered read data; port k in bits [k*DATA_W +: DATA_W]
o_rd_valid  out  1  o_rd_data updated by the previous accepted read
o_stall  out  1  combinational load-use hazard; current read not accepted
i_ex_v  in  1  execute-stage result valid and destined for a register
i_ex_addr  in  ADDR_W  execute-stage destination
i_ex_data  in  DATA_W  execute-stage ALU result
i_wr_en  in  1  writeback enable
i_wr_addr  in  ADDR_W  writeback destination
i_wr_data  in  DATA_W  writeback data (ALU or load)
i_link_en  in  1  write link value into register NREGS-1
i_link_data  in  DATA_W  return PC for call/callr
i_ld_issue  in  1  a load targeting i_ld_addr enters execute
i_ld_addr  in  ADDR_W  load destination
o_tb_regs  out  NREGS*DATA_W  flattened register contents for the testbench

Behaviour:
- Reset (sync, clk rising with reset=1): all registers 0; pending scoreboard 0; o_rd_data 0; o_rd_valid 0. Any write, link or issue in the same cycle is discarded.
- Accepted read: i_rd_en & !o_stall. On clk, each port k loads its value; 1-cycle latency. o_rd_valid <= accepted read.
- No accepted read: o_rd_data holds and o_rd_valid <= 0.
- Read source priority per port, sampled the same cycle:
  1. i_ex_v & i_ex_addr==addr -> i_ex_data.
  2. Else i_wr_en & i_wr_addr==addr -> i_wr_data.
  3. Else i_link_en & addr==NREGS-1 & !(i_wr_en & i_wr_addr==NREGS-1) -> i_link_data.
  4. Else the array value.
- Write: i_wr_en writes i_wr_data at clk.
- Link: i_link_en writes register NREGS-1 only if the write port is not also targeting NREGS-1. The write port always has priority.
- Scoreboard, pending[NREGS]:
  - Set at clk when i_ld_issue & !o_stall.
  - Cleared at clk when i_wr_en targets that address.
  - Set and clear on the same address in the same cycle: set wins (the younger load).
- o_stall = i_rd_en & OR over k of (pending[addr_k] & !(i_wr_en & i_wr_addr==addr_k)).
  - The execute bypass never resolves a pending load, because load data does not exist at execute.
- While o_stall=1: no o_rd_data update, i_ld_issue ignored, writes and links proceed normally.
- Duplicate addresses across ports are legal; all ports return identical data.
- o_tb_regs reflects array contents only, with no bypass.

Optional Feature:
ZERO_REG_EN:
- When defined: register 0 is hardwired to 0.
  - Writes, links and ld_issue to address 0 are ignored.
  - Reads of address 0 return 0 regardless of bypass sources.
  - pending[0] is never set, and o_tb_regs slot 0 reads 0.
- When undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then read ports 0/1 at addresses 3/5 -> next cycle o_rd_data = 0/0, o_rd_valid=1, all o_tb_regs 0.
- Write r2=0x1234 with a same-cycle read of r2 -> o_rd_data port0 = 0x1234 after one clk; r2=0x1234 in o_tb_regs.
- Same cycle: i_ex_v to r4=0x00AA, i_wr_en to r4=0x5555, read r4 -> 0x00AA (execute wins); r4 array = 0x5555.
- i_ld_issue to r6, then read r6 -> o_stall=1 and o_rd_data held. Next cycle i_wr_en r6=0xBEEF with a read of r6 -> o_stall=0, data 0xBEEF, pending cleared.
- i_link_en=1 with 0x0042 and i_wr_en to r7=0x7777 in the same cycle -> r7=0x7777. Link alone -> r7=0x0042.
- With ZERO_REG_EN: write r0=0xFFFF, then read r0 -> 0x0000. Without it -> 0xFFFF.

Source files
------------

// File: rtl/pipe_regfile_fwd.sv
// Register file with NRD registered read ports, EX/WB forwarding, a link-register write and a load-use scoreboard.
// Optional ZERO_REG_EN: register 0 hardwired to zero.
module pipe_regfile_fwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned NRD    = 2,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rd_en,
  input  logic [NRD*ADDR_W-1:0]   i_rd_addr,
  output logic [NRD*DATA_W-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_stall,
  input  logic                    i_ex_v,
  input  logic [ADDR_W-1:0]       i_ex_addr,
  input  logic [DATA_W-1:0]       i_ex_data,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_link_en,
  input  logic [DATA_W-1:0]       i_link_data,
  input  logic                    i_ld_issue,
  input  logic [ADDR_W-1:0]       i_ld_addr,
  output logic [NREGS*DATA_W-1:0] o_tb_regs
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0]     regs [NREGS];
  logic [NREGS-1:0]      pending;
  logic [NRD*DATA_W-1:0] rd_next;
  logic                  stall_c;
  logic                  wr_ok;
  logic                  link_ok;
  logic                  ld_ok;
  logic [ADDR_W-1:0]     a;

  assign wr_ok   = i_wr_en && !(ZERO_REG && (i_wr_addr == '0));
  assign link_ok = i_link_en && !(i_wr_en && (i_wr_addr == LINK_ADDR));
  assign ld_ok   = i_ld_issue && !stall_c && !(ZERO_REG && (i_ld_addr == '0));
  assign o_stall = stall_c;

  // Per-port forwarding select and load-use hazard detection.
  always_comb begin
    rd_next = '0;
    stall_c = 1'b0;
    a       = '0;
    for (int k = 0; k < NRD; k++) begin
      a = i_rd_addr[k*ADDR_W +: ADDR_W];
      if (pending[a] && !(i_wr_en && (i_wr_addr == a)))
        stall_c = 1'b1;
      if (ZERO_REG && (a == '0))
        rd_next[k*DATA_W +: DATA_W] = '0;
      else if (i_ex_v && (i_ex_addr == a))
        rd_next[k*DATA_W +: DATA_W] = i_ex_data;
      else if (i_wr_en && (i_wr_addr == a))
        rd_next[k*DATA_W +: DATA_W] = i_wr_data;
      else if (link_ok && (a == LINK_ADDR))
        rd_next[k*DATA_W +: DATA_W] = i_link_data;
      else
        rd_next[k*DATA_W +: DATA_W] = regs[a];
    end
    stall_c = stall_c && i_rd_en;
  end

  // Array, scoreboard and read-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending    <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      if (wr_ok)   regs[i_wr_addr] <= i_wr_data;
      if (link_ok) regs[LINK_ADDR] <= i_link_data;
      // A same-cycle issue belongs to a younger load, so set beats clear.
      for (int i = 0; i < NREGS; i++) begin
        if (ld_ok && (i_ld_addr == ADDR_W'(i)))
          pending[i] <= 1'b1;
        else if (i_wr_en && (i_wr_addr == ADDR_W'(i)))
          pending[i] <= 1'b0;
      end
      o_rd_valid <= i_rd_en && !stall_c;
      if (i_rd_en && !stall_c) o_rd_data <= rd_next;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_tb_regs
    assign o_tb_regs[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_pipe_regfile_fwd.sv
// Testbench for pipe_regfile_fwd: directed vector table, reset checks and random traffic against a reference model.
module tb_pipe_regfile_fwd;

`ifdef ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         i_rd_en;
  logic [5:0]   i_rd_addr;
  logic [31:0]  o_rd_data;
  logic         o_rd_valid;
  logic         o_stall;
  logic         i_ex_v;
  logic [2:0]   i_ex_addr;
  logic [15:0]  i_ex_data;
  logic         i_wr_en;
  logic [2:0]   i_wr_addr;
  logic [15:0]  i_wr_data;
  logic         i_link_en;
  logic [15:0]  i_link_data;
  logic         i_ld_issue;
  logic [2:0]   i_ld_addr;
  logic [127:0] o_tb_regs;

  pipe_regfile_fwd dut (
    .clk(clk), .reset(reset), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_stall(o_stall),
    .i_ex_v(i_ex_v), .i_ex_addr(i_ex_addr), .i_ex_data(i_ex_data),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_link_en(i_link_en), .i_link_data(i_link_data),
    .i_ld_issue(i_ld_issue), .i_ld_addr(i_ld_addr), .o_tb_regs(o_tb_regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd; logic [2:0] a0; logic [2:0] a1;
    logic exv; logic [2:0] exa; logic [15:0] exd;
    logic wr; logic [2:0] wra; logic [15:0] wrd;
    logic lk; logic [15:0] lkd;
    logic ld; logic [2:0] lda;
    logic es; logic ev; logic [15:0] ed0; logic [15:0] ed1;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  logic [15:0] m_rd   [2];
  bit          m_valid;
  bit          last_stall;

  function automatic vec_t mk(input logic rd, input logic [2:0] a0, input logic [2:0] a1,
                              input logic exv, input logic [2:0] exa, input logic [15:0] exd,
                              input logic wr, input logic [2:0] wra, input logic [15:0] wrd,
                              input logic lk, input logic [15:0] lkd,
                              input logic ld, input logic [2:0] lda,
                              input logic es, input logic ev, input logic [15:0] ed0, input logic [15:0] ed1);
    vec_t v;
    v.rd = rd; v.a0 = a0; v.a1 = a1; v.exv = exv; v.exa = exa; v.exd = exd;
    v.wr = wr; v.wra = wra; v.wrd = wrd; v.lk = lk; v.lkd = lkd; v.ld = ld; v.lda = lda;
    v.es = es; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Value a read of address a sees this cycle under the given inputs.
  function automatic logic [15:0] m_fwd(input vec_t v, input logic [2:0] a);
    if (Z && a == 3'd0)                 return 16'h0000;
    if (v.exv && v.exa == a)            return v.exd;
    if (v.wr && v.wra == a)             return v.wrd;
    if (v.lk && a == 3'd7)              return v.lkd;
    return m_regs[a];
  endfunction

  task automatic step(input vec_t v, input bit rst, input string tag);
    bit st;
    logic [127:0] flat;
    logic [15:0] n0, n1;
    reset = rst; i_rd_en = v.rd; i_rd_addr = {v.a1, v.a0};
    i_ex_v = v.exv; i_ex_addr = v.exa; i_ex_data = v.exd;
    i_wr_en = v.wr; i_wr_addr = v.wra; i_wr_data = v.wrd;
    i_link_en = v.lk; i_link_data = v.lkd; i_ld_issue = v.ld; i_ld_addr = v.lda;
    #1;
    st = v.rd && ((m_pend[v.a0] && !(v.wr && v.wra == v.a0)) ||
                  (m_pend[v.a1] && !(v.wr && v.wra == v.a1)));
    last_stall = o_stall;
    if (!rst) chk({tag, " stall"}, 128'(o_stall), 128'(st));
    n0 = m_fwd(v, v.a0);
    n1 = m_fwd(v, v.a1);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_rd[0] = '0; m_rd[1] = '0; m_valid = 0;
    end else begin
      m_valid = v.rd && !st;
      if (m_valid) begin m_rd[0] = n0; m_rd[1] = n1; end
      if (v.lk) m_regs[7] = v.lkd;
      if (v.wr && !(Z && v.wra == 3'd0)) m_regs[v.wra] = v.wrd;
      if (v.wr) m_pend[v.wra] = 0;
      if (v.ld && !st && !(Z && v.lda == 3'd0)) m_pend[v.lda] = 1;
    end
    #1;
    for (int i = 0; i < 8; i++) flat[i*16 +: 16] = m_regs[i];
    chk({tag, " valid"}, 128'(o_rd_valid), 128'(m_valid));
    chk({tag, " rd_data"}, 128'(o_rd_data), 128'({m_rd[1], m_rd[0]}));
    chk({tag, " tb_regs"}, o_tb_regs, flat);
  endtask

  vec_t tbl [19];
  vec_t idle;
  vec_t rv;
  logic [15:0] r0v;

  initial begin
    r0v = Z ? 16'h0000 : 16'hFFFF;
    idle = mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0);
    for (int i = 0; i < 8; i++) begin m_regs[i] = 'x; m_pend[i] = 0; end

    // Reset with garbage traffic that must be discarded
    step(mk(1,3,5, 1,3,16'h1111, 1,3,16'h2222, 1,16'h3333, 1,3, 0,0,0,0), 1, "rst0");
    step(mk(1,3,5, 0,0,0, 1,5,16'h4444, 1,16'h5555, 1,5, 0,0,0,0), 1, "rst1");
    chk("reset valid", 128'(o_rd_valid), 128'(0));
    chk("reset tb_regs", o_tb_regs, 128'(0));

    //         rd a0 a1  exv exa exd        wr wra wrd         lk lkd         ld lda  es ev ed0         ed1
    tbl[0]  = mk(1,3,5,  0,0,0,            0,0,0,             0,0,            0,0,   0,1,16'h0000,   16'h0000);
    tbl[1]  = mk(1,2,2,  0,0,0,            1,2,16'h1234,      0,0,            0,0,   0,1,16'h1234,   16'h1234);
    tbl[2]  = mk(1,4,4,  1,4,16'h00AA,     1,4,16'h5555,      0,0,            0,0,   0,1,16'h00AA,   16'h00AA);
    tbl[3]  = mk(0,0,0,  0,0,0,            0,0,0,             0,0,            1,6,   0,0,16'h00AA,   16'h00AA);
    tbl[4]  = mk(1,6,6,  0,0,0,            0,0,0,             0,0,            0,0,   1,0,16'h00AA,   16'h00AA);
    tbl[5]  = mk(1,6,2,  0,0,0,            1,6,16'hBEEF,      0,0,            0,0,   0,1,16'hBEEF,   16'h1234);
    tbl[6]  = mk(1,6,6,  0,0,0,            0,0,0,             0,0,            0,0,   0,1,16'hBEEF,   16'hBEEF);
    tbl[7]  = mk(1,7,7,  0,0,0,            1,7,16'h7777,      1,16'h0042,     0,0,   0,1,16'h7777,   16'h7777);
    tbl[8]  = mk(1,7,0,  0,0,0,            0,0,0,             1,16'h0042,     0,0,   0,1,16'h0042,   16'h0000);
    tbl[9]  = mk(1,7,4,  0,0,0,            0,0,0,             0,0,            0,0,   0,1,16'h0042,   16'h5555);
    tbl[10] = mk(0,0,0,  0,0,0,            1,0,16'hFFFF,      0,0,            0,0,   0,0,16'h0042,   16'h5555);
    tbl[11] = mk(1,0,0,  0,0,0,            0,0,0,             0,0,            0,0,   0,1,r0v,        r0v);
    tbl[12] = mk(0,0,0,  0,0,0,            1,3,16'h0101,      0,0,            1,3,   0,0,r0v,        r0v);
    tbl[13] = mk(1,3,3,  0,0,0,            0,0,0,             0,0,            0,0,   1,0,r0v,        r0v);
    tbl[14] = mk(1,3,3,  0,0,0,            1,3,16'h0202,      0,0,            0,0,   0,1,16'h0202,   16'h0202);
    tbl[15] = mk(0,0,0,  0,0,0,            0,0,0,             0,0,            1,1,   0,0,16'h0202,   16'h0202);
    tbl[16] = mk(1,1,1,  0,0,0,            0,0,0,             0,0,            1,5,   1,0,16'h0202,   16'h0202);
    tbl[17] = mk(1,5,5,  0,0,0,            0,0,0,             0,0,            0,0,   0,1,16'h0000,   16'h0000);
    tbl[18] = mk(1,1,5,  0,0,0,            1,1,16'h0A0A,      0,0,            0,0,   0,1,16'h0A0A,   16'h0000);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i], 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl stall", i), 128'(last_stall), 128'(tbl[i].es));
      chk($sformatf("vec%0d tbl valid", i), 128'(o_rd_valid), 128'(tbl[i].ev));
      chk($sformatf("vec%0d tbl data", i), 128'(o_rd_data), 128'({tbl[i].ed1, tbl[i].ed0}));
    end
    chk("r4 array", 128'(o_tb_regs[4*16 +: 16]), 128'(16'h5555));
    chk("r0 array", 128'(o_tb_regs[15:0]), 128'(r0v));

    // Execute bypass to a pending register must still stall
    step(mk(0,0,0, 0,0,0, 0,0,0, 0,0, 1,2, 0,0,0,0), 0, "exld");
    step(mk(1,2,2, 1,2,16'h9999, 0,0,0, 0,0, 0,0, 0,0,0,0), 0, "exst");
    chk("ex no resolve", 128'(last_stall), 128'(1));
    step(mk(1,2,2, 0,0,0, 1,2,16'h8888, 0,0, 0,0, 0,0,0,0), 0, "exwb");

    for (int n = 0; n < 400; n++) begin
      rv = idle;
      rv.rd  = ($urandom_range(0, 3) != 0);
      rv.a0  = 3'($urandom_range(0, 7)); rv.a1 = 3'($urandom_range(0, 7));
      rv.exv = ($urandom_range(0, 2) == 0); rv.exa = 3'($urandom_range(0, 7)); rv.exd = 16'($urandom);
      rv.wr  = ($urandom_range(0, 1) == 0); rv.wra = 3'($urandom_range(0, 7)); rv.wrd = 16'($urandom);
      rv.lk  = ($urandom_range(0, 4) == 0); rv.lkd = 16'($urandom);
      rv.ld  = ($urandom_range(0, 3) == 0); rv.lda = 3'($urandom_range(0, 7));
      step(rv, 0, $sformatf("rnd%0d", n));
    end

    // Mid-run reset clears array and scoreboard
    step(mk(1,1,2, 0,0,0, 1,1,16'hCAFE, 1,16'h0707, 1,2, 0,0,0,0), 1, "rst2");
    chk("rst2 tb_regs", o_tb_regs, 128'(0));
    step(mk(1,1,2, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0), 0, "post");
    chk("post stall", 128'(last_stall), 128'(0));
    chk("post data", 128'(o_rd_data), 128'(0));
    step(idle, 0, "end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
